// File: rtl/snn_delay_layer.sv
// rtl/snn_delay_layer.sv - LIF spiking layer with per-synapse axonal delays, one neuron evaluated per cycle.
// Optional per-neuron saturating spike counters are built when SNN_SPIKE_COUNT_EN is defined.
module snn_delay_layer #(
    parameter int M    = 8,
    parameter int N    = 8,
    parameter int WW   = 2,
    parameter int MPW  = 6,
    parameter int DW   = 3,
    parameter int DECW = 3,
    parameter int RPW  = 5,
    parameter int CW   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 step_valid,
    output logic                 step_ready,
    input  logic [M-1:0]         input_spikes,
    input  logic [N*M*WW-1:0]    weights,
    input  logic [N*M*DW-1:0]    delays,
    input  logic [MPW-1:0]       threshold,
    input  logic [DECW-1:0]      decay,
    input  logic [RPW-1:0]       refractory_period,
    output logic [N-1:0]         output_spikes,
    output logic [N*MPW-1:0]     membrane_potential_out,
    output logic                 output_data_ready,
    input  logic                 count_clear,
    output logic [N*CW-1:0]      spike_count
);

    localparam int HL = (1 << DW) - 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = MPW + WW + $clog2(M + 1) + 2;
    localparam logic signed [SW-1:0] VMAX = SW'((1 << MPW) - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     r_state;
    logic [IW-1:0]  r_idx;
    logic [M-1:0]   r_spk_q;
    logic [HL-1:0]  r_hist [M];
    logic [MPW-1:0] r_v [N];
    logic [RPW-1:0] r_ref [N];
    logic [N-1:0]   r_spk_sh;
    logic [N-1:0]   r_out_spk;
    logic           r_odr;

    logic [M-1:0]          w_bit;
    logic signed [WW-1:0]  w_wgt [M];
    logic signed [SW-1:0]  w_sum;
    logic signed [SW-1:0]  w_vnext;
    logic [MPW-1:0]        w_vclamp;
    logic                  w_refr;
    logic                  w_fire;
    logic                  w_last;
    logic [N-1:0]          w_sh_next;

    // History is shared per input; each synapse just picks its tap.
    for (genvar m = 0; m < M; m++) begin : g_syn
        logic [DW-1:0] w_d;
        assign w_d      = delays[(int'(r_idx) * M + m) * DW +: DW];
        assign w_wgt[m] = weights[(int'(r_idx) * M + m) * WW +: WW];
        assign w_bit[m] = (w_d == '0) ? r_spk_q[m] : r_hist[m][w_d - 1'b1];
    end

    always_comb begin
        w_sum = '0;
        for (int m = 0; m < M; m++) begin
            if (w_bit[m]) begin
                w_sum = w_sum + SW'(w_wgt[m]);
            end
        end
        w_vnext = $signed({{(SW-MPW){1'b0}}, r_v[r_idx]})
                - $signed({{(SW-DECW){1'b0}}, decay})
                + w_sum;
        if (w_vnext < 0) begin
            w_vclamp = '0;
        end else if (w_vnext > VMAX) begin
            w_vclamp = VMAX[MPW-1:0];
        end else begin
            w_vclamp = w_vnext[MPW-1:0];
        end
        w_refr           = (r_ref[r_idx] != '0);
        w_fire           = !w_refr && (w_vclamp >= threshold);
        w_last           = (r_idx == IW'(N - 1));
        w_sh_next        = r_spk_sh;
        w_sh_next[r_idx] = w_fire;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_spk_q   <= '0;
            r_spk_sh  <= '0;
            r_out_spk <= '0;
            r_odr     <= 1'b0;
            for (int m = 0; m < M; m++) begin
                r_hist[m] <= '0;
            end
            for (int n = 0; n < N; n++) begin
                r_v[n]   <= '0;
                r_ref[n] <= '0;
            end
        end else begin
            r_odr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (step_valid && step_ready) begin
                        r_spk_q  <= input_spikes;
                        r_idx    <= '0;
                        r_spk_sh <= '0;
                        r_state  <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (w_refr) begin
                        r_ref[r_idx] <= r_ref[r_idx] - 1'b1;
                        r_v[r_idx]   <= '0;
                    end else if (w_fire) begin
                        r_v[r_idx]   <= '0;
                        r_ref[r_idx] <= refractory_period;
                    end else begin
                        r_v[r_idx]   <= w_vclamp;
                    end
                    r_spk_sh <= w_sh_next;
                    // Publish spikes together with the ready pulse so both are seen in DONE.
                    if (w_last) begin
                        r_out_spk <= w_sh_next;
                        r_odr     <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    for (int m = 0; m < M; m++) begin
                        r_hist[m] <= {r_hist[m][HL-2:0], r_spk_q[m]};
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign step_ready        = (r_state == S_IDLE) && enable;
    assign output_spikes     = r_out_spk;
    assign output_data_ready = r_odr;

    for (genvar n = 0; n < N; n++) begin : g_mem
        assign membrane_potential_out[n*MPW +: MPW] = r_v[n];
    end

`ifdef SNN_SPIKE_COUNT_EN
    logic [CW-1:0] r_cnt [N];

    always_ff @(posedge clk) begin
        if (reset || count_clear) begin
            for (int n = 0; n < N; n++) begin
                r_cnt[n] <= '0;
            end
        end else if (r_state == S_DONE) begin
            for (int n = 0; n < N; n++) begin
                if (r_out_spk[n] && (r_cnt[n] != '1)) begin
                    r_cnt[n] <= r_cnt[n] + 1'b1;
                end
            end
        end
    end

    for (genvar n = 0; n < N; n++) begin : g_cnt
        assign spike_count[n*CW +: CW] = r_cnt[n];
    end
`else
    logic w_unused_clear;
    assign w_unused_clear = count_clear;
    assign spike_count    = '0;
`endif

endmodule

// File: tb/tb_snn_delay_layer.sv
// tb/tb_snn_delay_layer.sv - randomized and directed checks of snn_delay_layer against a timestep-level model.
module tb_snn_delay_layer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         step_valid = 1'b0;
    logic         step_ready;
    logic [7:0]   input_spikes = '0;
    logic [127:0] weights = '0;
    logic [191:0] delays = '0;
    logic [5:0]   threshold = '0;
    logic [2:0]   decay = '0;
    logic [4:0]   refractory_period = '0;
    logic [7:0]   output_spikes;
    logic [47:0]  membrane_potential_out;
    logic         output_data_ready;
    logic         count_clear = 1'b0;
    logic [63:0]  spike_count;

    int tests = 0;
    int failed = 0;

    int cw [8][8];
    int cd [8][8];
    int cfg_thr, cfg_decay, cfg_rp;

    int         mv [8];
    int         mref [8];
    int         mcnt [8];
    logic [7:0] past [7];
    logic [7:0] exp_spk;
    bit         rdy_in_eval;

    snn_delay_layer dut (
        .clk(clk), .reset(reset), .enable(enable),
        .step_valid(step_valid), .step_ready(step_ready),
        .input_spikes(input_spikes), .weights(weights), .delays(delays),
        .threshold(threshold), .decay(decay), .refractory_period(refractory_period),
        .output_spikes(output_spikes), .membrane_potential_out(membrane_potential_out),
        .output_data_ready(output_data_ready),
        .count_clear(count_clear), .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int n = 0; n < 8; n++) begin
            mv[n] = 0; mref[n] = 0; mcnt[n] = 0;
        end
        for (int k = 0; k < 7; k++) past[k] = '0;
    endtask

    task automatic model_step(input logic [7:0] sp);
        int s, vp;
        bit b;
        for (int n = 0; n < 8; n++) begin
            exp_spk[n] = 1'b0;
            if (mref[n] != 0) begin
                mref[n] = mref[n] - 1;
                mv[n] = 0;
            end else begin
                s = 0;
                for (int m = 0; m < 8; m++) begin
                    b = (cd[n][m] == 0) ? sp[m] : past[cd[n][m]-1][m];
                    if (b) s += cw[n][m];
                end
                vp = mv[n] - cfg_decay + s;
                if (vp < 0) vp = 0;
                if (vp > 63) vp = 63;
                if (vp >= cfg_thr) begin
                    exp_spk[n] = 1'b1;
                    mv[n] = 0;
                    mref[n] = cfg_rp;
                    if (mcnt[n] < 255) mcnt[n]++;
                end else begin
                    mv[n] = vp;
                end
            end
        end
        for (int k = 6; k > 0; k--) past[k] = past[k-1];
        past[0] = sp;
    endtask

    task automatic apply_cfg();
        for (int n = 0; n < 8; n++) begin
            for (int m = 0; m < 8; m++) begin
                weights[(n*8+m)*2 +: 2] = cw[n][m][1:0];
                delays[(n*8+m)*3 +: 3]  = cd[n][m][2:0];
            end
        end
        threshold         = cfg_thr[5:0];
        decay             = cfg_decay[2:0];
        refractory_period = cfg_rp[4:0];
    endtask

    task automatic set_all(input int w, input int d);
        for (int n = 0; n < 8; n++)
            for (int m = 0; m < 8; m++) begin
                cw[n][m] = w; cd[n][m] = d;
            end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        step_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_step(input logic [7:0] sp, input bit hold, output int lat);
        int cyc;
        bit seen;
        logic [47:0] exp_mem;
        model_step(sp);
        @(negedge clk);
        step_valid = 1'b1;
        input_spikes = sp;
        cyc = 0;
        while (!step_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (!step_ready) begin
            failed++;
            $display("FAIL accept_timeout: step_ready=%0b required 1", step_ready);
        end
        @(posedge clk);
        #1;
        if (!hold) step_valid = 1'b0;
        lat = 0;
        seen = 1'b0;
        rdy_in_eval = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (output_data_ready) seen = 1'b1;
            else if (step_ready) rdy_in_eval = 1'b1;
        end
        step_valid = 1'b0;
        tests++;
        if (!seen) begin
            failed++;
            $display("FAIL done_timeout: output_data_ready=%0b required 1", output_data_ready);
        end
        for (int n = 0; n < 8; n++) exp_mem[n*6 +: 6] = mv[n][5:0];
        tests++;
        if (output_spikes !== exp_spk) begin
            failed++;
            $display("FAIL step_spikes: got %h required %h", output_spikes, exp_spk);
        end
        tests++;
        if (membrane_potential_out !== exp_mem) begin
            failed++;
            $display("FAIL step_membrane: got %h required %h", membrane_potential_out, exp_mem);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_dut();
        enable = 1'b1;
        @(negedge clk);
        tests++;
        if (step_ready !== 1'b1 || output_spikes !== 8'h00 || membrane_potential_out !== 48'h0
            || output_data_ready !== 1'b0) begin
            failed++;
            $display("FAIL reset_state: rdy=%0b spk=%h mem=%h odr=%0b required 1 00 0 0",
                     step_ready, output_spikes, membrane_potential_out, output_data_ready);
        end
    endtask

    task automatic test_delay();
        int lat;
        logic [7:0] seq [5] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        set_all(0, 0);
        cw[0][0] = 1; cd[0][0] = 3;
        cfg_thr = 1; cfg_decay = 0; cfg_rp = 0;
        apply_cfg();
        for (int s = 0; s < 5; s++) begin
            do_step(seq[s], 1'b0, lat);
            tests++;
            if (output_spikes[0] !== (s == 3) || membrane_potential_out[5:0] !== 6'd0) begin
                failed++;
                $display("FAIL delay3_step%0d: spk0=%0b v0=%0d required %0b 0",
                         s, output_spikes[0], membrane_potential_out[5:0], s == 3);
            end
        end
    endtask

    task automatic test_accumulate();
        int lat;
        for (int m = 0; m < 8; m++) begin
            cw[1][m] = 1; cd[1][m] = 0;
        end
        cfg_thr = 10; cfg_decay = 1; cfg_rp = 0;
        apply_cfg();
        do_step(8'hFF, 1'b0, lat);
        tests++;
        if (membrane_potential_out[11:6] !== 6'd7 || output_spikes[1] !== 1'b0) begin
            failed++;
            $display("FAIL accum_first: v1=%0d spk1=%0b required 7 0",
                     membrane_potential_out[11:6], output_spikes[1]);
        end
        do_step(8'hFF, 1'b0, lat);
        tests++;
        if (membrane_potential_out[11:6] !== 6'd0 || output_spikes[1] !== 1'b1) begin
            failed++;
            $display("FAIL accum_fire: v1=%0d spk1=%0b required 0 1",
                     membrane_potential_out[11:6], output_spikes[1]);
        end
    endtask

    task automatic test_refractory();
        int lat;
        int ev [6] = '{8, 0, 0, 0, 8, 0};
        cfg_thr = 10; cfg_decay = 0; cfg_rp = 2;
        apply_cfg();
        for (int s = 0; s < 6; s++) begin
            do_step(8'hFF, 1'b0, lat);
            tests++;
            if (output_spikes[1] !== (s == 1 || s == 5) || int'(membrane_potential_out[11:6]) != ev[s]) begin
                failed++;
                $display("FAIL refractory_step%0d: spk1=%0b v1=%0d required %0b %0d",
                         s, output_spikes[1], membrane_potential_out[11:6], s == 1 || s == 5, ev[s]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        reset_dut();
        set_all(-1, 0);
        cfg_thr = 10; cfg_decay = 0; cfg_rp = 0;
        apply_cfg();
        for (int s = 0; s < 2; s++) begin
            do_step(8'hFF, 1'b1, lat);
            tests++;
            if (lat != 9 || rdy_in_eval !== 1'b0) begin
                failed++;
                $display("FAIL latency_step%0d: lat=%0d ready_in_eval=%0b required 9 0", s, lat, rdy_in_eval);
            end
            tests++;
            if (output_spikes !== 8'h00 || membrane_potential_out !== 48'h0) begin
                failed++;
                $display("FAIL inhibit_step%0d: spk=%h mem=%h required 00 0",
                         s, output_spikes, membrane_potential_out);
            end
        end
    endtask

    task automatic test_reset_mid_step();
        int lat, odr_cnt;
        set_all(1, 0);
        cfg_thr = 60; cfg_decay = 0; cfg_rp = 0;
        apply_cfg();
        do_step(8'hFF, 1'b0, lat);
        @(negedge clk);
        step_valid = 1'b1;
        input_spikes = 8'hFF;
        @(posedge clk);
        #1 step_valid = 1'b0;
        odr_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            odr_cnt += int'(output_data_ready);
        end
        reset = 1'b1;
        @(negedge clk);
        odr_cnt += int'(output_data_ready);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (step_ready !== 1'b1 || membrane_potential_out !== 48'h0 || output_spikes !== 8'h00) begin
            failed++;
            $display("FAIL mid_reset_state: rdy=%0b mem=%h spk=%h required 1 0 00",
                     step_ready, membrane_potential_out, output_spikes);
        end
        repeat (12) begin
            @(negedge clk);
            odr_cnt += int'(output_data_ready);
        end
        tests++;
        if (odr_cnt != 0) begin
            failed++;
            $display("FAIL mid_reset_odr: pulses=%0d required 0", odr_cnt);
        end
        model_reset();
    endtask

    task automatic test_random();
        int lat;
        logic [7:0] sp;
        reset_dut();
        set_all(1, 0);
        cfg_thr = 0; cfg_decay = 0; cfg_rp = 0;
        apply_cfg();
        do_step(8'h00, 1'b0, lat);
        tests++;
        if (output_spikes !== 8'hFF) begin
            failed++;
            $display("FAIL thr_zero: spk=%h required ff", output_spikes);
        end
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < 8; n++)
                for (int m = 0; m < 8; m++) begin
                    cw[n][m] = int'($urandom_range(0, 3)) - 2;
                    cd[n][m] = int'($urandom_range(0, 7));
                end
            cfg_thr   = int'($urandom_range(0, 25));
            cfg_decay = int'($urandom_range(0, 3));
            cfg_rp    = int'($urandom_range(0, 3));
            apply_cfg();
            for (int s = 0; s < 15; s++) begin
                sp = 8'($urandom);
                do_step(sp, 1'($urandom_range(0, 1)), lat);
            end
        end
        for (int n = 0; n < 8; n++) begin
            tests++;
`ifdef SNN_SPIKE_COUNT_EN
            if (int'(spike_count[n*8 +: 8]) != mcnt[n]) begin
                failed++;
                $display("FAIL spike_count%0d: got %0d required %0d", n, spike_count[n*8 +: 8], mcnt[n]);
            end
`else
            if (spike_count[n*8 +: 8] !== 8'd0) begin
                failed++;
                $display("FAIL spike_count%0d: got %0d required 0", n, spike_count[n*8 +: 8]);
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        set_all(0, 0);
        cfg_thr = 0; cfg_decay = 0; cfg_rp = 0;
        test_reset();
        test_delay();
        test_accumulate();
        test_refractory();
        test_back_to_back();
        test_reset_mid_step();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
